// File: rtl/dlbf_capture_pkg.sv
// Shared types and widths for the DLBF capture slave (state encoding, counter widths).
// Pure declarations: no latency, no flow control.
package dlbf_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam int CNT_W  = 12;
  localparam int ERR_W  = 8;
  localparam int CSUM_W = 32;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

endpackage

// File: rtl/dlbf_capture_ram.sv
// Simple dual-port capture RAM: write port A, read-first read port B, single clock.
// Write lands on the clock edge; read data is registered, valid 1 cycle after rd_en; no backpressure.
module dlbf_capture_ram #(
  parameter int TDATA_WIDTH = 64,
  parameter int RAM_DEPTH   = 1024,
  parameter int AW          = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [TDATA_WIDTH-1:0] wr_data,
  input  logic                   rd_en,
  input  logic                   rd_ok,
  input  logic [AW-1:0]          rd_addr,
  output logic [TDATA_WIDTH-1:0] rd_data
);

  logic [TDATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [TDATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Non-blocking read of mem gives old data on a same-address write (read-first).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= rd_ok ? mem[rd_addr] : '0;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dlbf_capture_slave.sv
// AXI4-Stream slave capturing niter x block_size beats into local RAM; 1 beat/cycle, 1-cycle write, 1-cycle read port.
// tready is registered and only high in CAPTURE; optional checksum output under `DLBF_CAPTURE_CHECKSUM_EN.
module dlbf_capture_slave
  import dlbf_capture_pkg::*;
#(
  parameter int TDATA_WIDTH = 64,
  parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
  parameter int RAM_DEPTH   = 1024,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                   s_axis_clk,
  input  logic                   s_axis_rst,
  input  logic                   s00_axis_tvalid,
  output logic                   s00_axis_tready,
  input  logic [TDATA_WIDTH-1:0] s00_axis_tdata,
  input  logic [TKEEP_WIDTH-1:0] s00_axis_tkeep,
  input  logic                   s00_axis_tlast,
  input  logic                   go,
  input  logic [CNT_W-1:0]       niter,
  input  logic [CNT_W-1:0]       block_size,
  output logic                   done,
  output logic [ADDR_WIDTH-1:0]  addr_wire,
  output logic [ERR_W-1:0]       tlast_err,
  output logic                   overflow,
  input  logic                   rd_en,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [TDATA_WIDTH-1:0] rd_data
`ifdef DLBF_CAPTURE_CHECKSUM_EN
  ,
  output logic [CSUM_W-1:0]      checksum
`endif
);

  localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  state_e              state_q, state_d;
  logic                tready_q, tready_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    niter_q, niter_d;
  logic [CNT_W-1:0]    bsize_q, bsize_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]    blk_cnt_q, blk_cnt_d;
  logic [RAM_AW-1:0]   addr_q, addr_d;
  logic [ERR_W-1:0]    tlast_err_q, tlast_err_d;
  logic                overflow_q, overflow_d;

  logic params_ok, accept, last_beat, last_blk, run_start, addr_wrap, rd_ok;
  logic unused_tkeep;

  assign params_ok = (niter != '0) && (block_size != '0);
  assign accept    = s00_axis_tvalid && tready_q;
  assign last_beat = (beat_cnt_q == bsize_q - CNT_W'(1));
  assign last_blk  = (blk_cnt_q == niter_q - CNT_W'(1));
  assign run_start = go && params_ok && (state_q != CAPTURE);
  assign addr_wrap = (addr_q == RAM_AW'(RAM_DEPTH - 1));

  always_ff @(posedge s_axis_clk or posedge s_axis_rst) begin
    if (s_axis_rst) begin
      state_q  <= IDLE;
      tready_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tready_q <= tready_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go && params_ok) state_d = CAPTURE;
      CAPTURE: if (accept && last_beat && last_blk) state_d = DONE;
      DONE:    if (go) state_d = params_ok ? CAPTURE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the next state so they come straight off flops.
  always_comb begin
    tready_d = (state_d == CAPTURE);
    done_d   = (state_d == DONE);
  end

  always_comb begin
    niter_d     = niter_q;
    bsize_d     = bsize_q;
    beat_cnt_d  = beat_cnt_q;
    blk_cnt_d   = blk_cnt_q;
    addr_d      = addr_q;
    tlast_err_d = tlast_err_q;
    overflow_d  = overflow_q;
    if (run_start) begin
      niter_d     = niter;
      bsize_d     = block_size;
      beat_cnt_d  = '0;
      blk_cnt_d   = '0;
      addr_d      = '0;
      tlast_err_d = '0;
      overflow_d  = 1'b0;
    end else if (accept) begin
      addr_d = addr_wrap ? '0 : addr_q + RAM_AW'(1);
      if (addr_wrap) begin
        overflow_d = 1'b1;
      end
      // Block framing comes from beat_cnt; tlast is only audited.
      if (last_beat) begin
        beat_cnt_d = '0;
        blk_cnt_d  = blk_cnt_q + CNT_W'(1);
      end else begin
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
      if (s00_axis_tlast != last_beat) begin
        tlast_err_d = sat_inc(tlast_err_q);
      end
    end
  end

  always_ff @(posedge s_axis_clk or posedge s_axis_rst) begin
    if (s_axis_rst) begin
      niter_q     <= '0;
      bsize_q     <= '0;
      beat_cnt_q  <= '0;
      blk_cnt_q   <= '0;
      addr_q      <= '0;
      tlast_err_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      niter_q     <= niter_d;
      bsize_q     <= bsize_d;
      beat_cnt_q  <= beat_cnt_d;
      blk_cnt_q   <= blk_cnt_d;
      addr_q      <= addr_d;
      tlast_err_q <= tlast_err_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef DLBF_CAPTURE_CHECKSUM_EN
  logic [CSUM_W-1:0] csum_q, csum_d, lane_fold;

  always_comb begin
    lane_fold = '0;
    for (int i = 0; i < TDATA_WIDTH / 32; i++) begin
      lane_fold = lane_fold ^ s00_axis_tdata[i*32 +: 32];
    end
    csum_d = csum_q;
    if (run_start) begin
      csum_d = '0;
    end else if (accept) begin
      csum_d = csum_q + lane_fold;
    end
  end

  always_ff @(posedge s_axis_clk or posedge s_axis_rst) begin
    if (s_axis_rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

  assign rd_ok = ({1'b0, rd_addr} < (ADDR_WIDTH + 1)'(RAM_DEPTH));

  dlbf_capture_ram #(
    .TDATA_WIDTH (TDATA_WIDTH),
    .RAM_DEPTH   (RAM_DEPTH),
    .AW          (RAM_AW)
  ) u_ram (
    .clk     (s_axis_clk),
    .rst     (s_axis_rst),
    .wr_en   (accept),
    .wr_addr (addr_q),
    .wr_data (s00_axis_tdata),
    .rd_en   (rd_en),
    .rd_ok   (rd_ok),
    .rd_addr (rd_addr[RAM_AW-1:0]),
    .rd_data (rd_data)
  );

  assign unused_tkeep    = ^s00_axis_tkeep;
  assign s00_axis_tready = tready_q;
  assign done            = done_q;
  assign addr_wire       = ADDR_WIDTH'(addr_q);
  assign tlast_err       = tlast_err_q;
  assign overflow        = overflow_q;

endmodule
